// File: rtl/ps2_key_controller.sv
// Purpose : decodes PS/2 scancode-set-2 bytes (E0/F0 prefixes) into make/break events and queues them in a FWFT FIFO.
// Latency : an event is visible on evt_data/evt_count 1 cycle after the byte_valid rising edge; a pop updates the head next cycle.
// Backpressure: none toward the receiver; a push into a full FIFO (without a coincident pop) is dropped and sets sticky overflow.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   byte_in, byte_valid receiver byte and valid level (each rising edge is one byte)
//   evt_data            FIFO head {release, extended, scancode}
//   evt_empty, evt_full FIFO status, evt_count = number of queued events
//   evt_rd              one-cycle pop strobe (ignored when empty)
//   overflow, ovf_clr   sticky drop flag and its clear
module ps2_key_controller #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 2000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    output logic [9:0]               evt_data,
    output logic                     evt_empty,
    output logic                     evt_full,
    output logic [$clog2(DEPTH):0]   evt_count,
    input  logic                     evt_rd,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [31:0]   TMO_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    state_t      state, state_nxt;
    logic        bv_q;
    logic        new_byte;
    logic [31:0] timer;
    logic        timeout_hit;
    logic        push;
    logic [9:0]  push_dat;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          pop, push_ok, drop;

    // Keyboard housekeeping replies (BAT ok, ACK, echo, BAT fail, errors).
    function automatic logic is_housekeeping(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
               (b == 8'hFC) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    assign new_byte = byte_valid & ~bv_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bv_q <= 1'b0;
        else     bv_q <= byte_valid;
    end

    // A byte arriving in the timeout cycle takes priority over the timeout.
    assign timeout_hit = (state != ST_IDLE) && !new_byte && (timer == TMO_LAST);

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_dat  = '0;
        if (new_byte) begin
            case (state)
                ST_IDLE: begin
                    if (byte_in == 8'hE0)             state_nxt = ST_EXT;
                    else if (byte_in == 8'hF0)        state_nxt = ST_BRK;
                    else if (!is_housekeeping(byte_in)) begin
                        push     = 1'b1;
                        push_dat = {2'b00, byte_in};
                    end
                end
                ST_EXT: begin
                    if (byte_in == 8'hF0)      state_nxt = ST_EXT_BRK;
                    else if (byte_in != 8'hE0) begin
                        push      = 1'b1;
                        push_dat  = {2'b01, byte_in};
                        state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (byte_in == 8'hE0)      state_nxt = ST_EXT;
                    else if (byte_in != 8'hF0) begin
                        push      = 1'b1;
                        push_dat  = {2'b10, byte_in};
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    if (byte_in == 8'hE0)      state_nxt = ST_EXT;
                    else if (byte_in == 8'hF0) state_nxt = ST_BRK;
                    else begin
                        push      = 1'b1;
                        push_dat  = {2'b11, byte_in};
                        state_nxt = ST_IDLE;
                    end
                end
            endcase
        end else if (timeout_hit) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Timer restarts on any byte or state change and only runs inside a prefix.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timer <= '0;
        else if (new_byte || (state_nxt != state) || (state == ST_IDLE))
            timer <= '0;
        else
            timer <= timer + 32'd1;
    end

    assign evt_empty = (count == '0);
    assign evt_full  = (count == FULL_CNT);
    assign evt_count = count;
    assign evt_data  = mem[rd_ptr];

    assign pop     = evt_rd && !evt_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push && (!evt_full || pop);
    assign drop    = push && evt_full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A new drop beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_ps2_key_controller.sv
// Purpose : self-checking bench for ps2_key_controller (DEPTH=4, TIMEOUT=16) with a queue-based event model.
// Latency : model expectations are compared 1 time unit after every rising clock edge.
// Backpressure: stimulus is driven on falling edges; the bench never waits on a DUT event.
module tb_ps2_key_controller;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_valid = 1'b0;
    logic [9:0]    evt_data;
    logic          evt_empty;
    logic          evt_full;
    logic [CW-1:0] evt_count;
    logic          evt_rd = 1'b0;
    logic          overflow;
    logic          ovf_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    ps2_key_controller #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .evt_data   (evt_data),
        .evt_empty  (evt_empty),
        .evt_full   (evt_full),
        .evt_count  (evt_count),
        .evt_rd     (evt_rd),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [9:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_bv  = 1'b0;
    logic       m_act = 1'b0;   // a prefix is pending
    logic       m_rel = 1'b0;
    logic       m_ext = 1'b0;
    int         m_age = 0;      // cycles since the last prefix byte

    always @(posedge clk) begin
        logic       nb, pop, have, dropped;
        logic [7:0] b;
        logic [9:0] ev;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0; m_bv = 1'b0; m_act = 1'b0;
            m_rel = 1'b0; m_ext = 1'b0; m_age = 0;
        end else begin
            nb   = byte_valid && !m_bv;
            m_bv = byte_valid;
            pop  = evt_rd && (mq.size() > 0);
            have = 1'b0;
            ev   = '0;
            b    = byte_in;
            if (nb) begin
                m_age = 0;
                if (b == 8'hE0) begin
                    m_act = 1'b1; m_ext = 1'b1; m_rel = 1'b0;
                end else if (b == 8'hF0) begin
                    m_ext = m_act && m_ext && !m_rel;
                    m_act = 1'b1; m_rel = 1'b1;
                end else if (m_act) begin
                    have = 1'b1; ev = {m_rel, m_ext, b}; m_act = 1'b0;
                end else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'h00, 8'hFF})) begin
                    have = 1'b1; ev = {2'b00, b};
                end
            end else if (m_act) begin
                m_age++;
                if (m_age >= TIMEOUT) m_act = 1'b0;
            end
            if (pop) void'(mq.pop_front());
            dropped = 1'b0;
            if (have) begin
                if (mq.size() < DEPTH) mq.push_back(ev);
                else dropped = 1'b1;
            end
            if (dropped)      m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("m_empty", 32'(evt_empty), 32'(mq.size() == 0));
        chk("m_count", 32'(evt_count), 32'(mq.size()));
        chk("m_full",  32'(evt_full),  32'(mq.size() == DEPTH));
        chk("m_ovf",   32'(overflow),  32'(m_ovf));
        if (mq.size() > 0) chk("m_data", 32'(evt_data), 32'(mq[0]));
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pop_expect(input logic [9:0] exp);
        chk("pop_data",  32'(evt_data), 32'(exp));
        chk("pop_empty", 32'(evt_empty), 32'd0);
        evt_rd = 1'b1;
        @(negedge clk);
        evt_rd = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_empty"}, 32'(evt_empty), 32'd1);
        chk({tag, "_count"}, 32'(evt_count), 32'd0);
        chk({tag, "_full"},  32'(evt_full),  32'd0);
        chk({tag, "_ovf"},   32'(overflow),  32'd0);
        chk({tag, "_data"},  32'(evt_data),  32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq [9];
        seq = '{8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hAA, 8'hFA};

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // single make code
        send(8'h1C);
        chk("make_count", 32'(evt_count), 32'd1);
        pop_expect(10'h01C);
        chk("make_empty_after_pop", 32'(evt_empty), 32'd1);

        // prefix decoding and housekeeping filter
        foreach (seq[i]) send(seq[i]);
        chk("seq_count", 32'(evt_count), 32'd3);
        pop_expect(10'h21C);
        pop_expect(10'h175);
        pop_expect(10'h375);
        chk("seq_empty", 32'(evt_empty), 32'd1);

        // timeout: 20-cycle gap discards the break
        send(8'hF0);
        repeat (18) @(negedge clk);
        send(8'h1C);
        pop_expect(10'h01C);
        // byte on the last allowed cycle still completes the break
        send(8'hF0);
        repeat (14) @(negedge clk);
        send(8'h1C);
        pop_expect(10'h21C);
        // one cycle later the prefix has expired
        send(8'hF0);
        repeat (15) @(negedge clk);
        send(8'h1C);
        pop_expect(10'h01C);

        // overflow
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
        chk("ovf_full",  32'(evt_full),  32'd1);
        chk("ovf_set",   32'(overflow),  32'd1);
        chk("ovf_count", 32'(evt_count), 32'd4);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // pop coincident with push while full
        chk("full_head", 32'(evt_data), 32'h010);
        byte_in    = 8'h22;
        byte_valid = 1'b1;
        evt_rd     = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        evt_rd     = 1'b0;
        chk("rdwr_count", 32'(evt_count), 32'd4);
        chk("rdwr_ovf",   32'(overflow),  32'd0);
        pop_expect(10'h011);
        pop_expect(10'h012);
        pop_expect(10'h013);
        pop_expect(10'h022);
        chk("drain_empty", 32'(evt_empty), 32'd1);

        // drop and clear in the same cycle: set wins
        for (int i = 0; i < 4; i++) send(8'h30 + 8'(i));
        @(negedge clk);
        byte_in    = 8'h34;
        byte_valid = 1'b1;
        ovf_clr    = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        ovf_clr    = 1'b0;
        chk("setwins_ovf", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        for (int i = 0; i < 4; i++) pop_expect(10'h030 + 10'(i));

        // pop while empty is ignored
        evt_rd = 1'b1;
        @(negedge clk);
        evt_rd = 1'b0;
        chk("empty_rd_count", 32'(evt_count), 32'd0);

        // held level counts once
        byte_in    = 8'h1C;
        byte_valid = 1'b1;
        repeat (10) @(negedge clk);
        byte_valid = 1'b0;
        @(negedge clk);
        chk("hold_count", 32'(evt_count), 32'd1);
        pop_expect(10'h01C);

        // reset mid-sequence
        send(8'h15);
        send(8'hE0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0;
        send(8'h75);
        pop_expect(10'h075);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_controller.md
# ps2_key_controller

Sequences raw bytes from the PS/2 receiver (`PS2Interface`: 8-bit `data_out` plus `valid`) into decoded key events. It tracks the scancode-set-2 prefix protocol (0xE0 extended, 0xF0 break), discards keyboard housekeeping bytes and queues complete make/break events in a small FIFO. The FIFO is drained by the CPU-side bus through a read-strobe handshake. The block sits between the PS/2 receiver and the system bus peripheral register file.

## Interface
- `DEPTH`, 8, event FIFO depth; power of 2, 2..64
- `TIMEOUT`, 2000000, clk cycles allowed between a prefix byte and the byte that follows it; >= 1
- `clk`  input  1  system clock, all logic on posedge
- `rst`  input  1  reset, asynchronous, active-high
- `byte_in`  input  8  received byte from the PS/2 receiver
- `byte_valid`  input  1  receiver valid level; each rising edge marks one new byte
- `evt_data`  output  10  FIFO head: {release, extended, scancode[7:0]}; valid when `evt_empty`=0
- `evt_empty`  output  1  FIFO empty
- `evt_full`  output  1  FIFO full
- `evt_count`  output  $clog2(DEPTH)+1  number of queued events
- `evt_rd`  input  1  one-cycle pop strobe
- `overflow`  output  1  sticky: an event was dropped because the FIFO was full
- `ovf_clr`  input  1  clears `overflow`

## Operation
- Edge detect: register `byte_valid` into `bv_q`; `new_byte = byte_valid & ~bv_q`. A level held high counts as exactly one byte.
- FSM states:
  - IDLE:
    - 0xE0 -> EXT.
    - 0xF0 -> BRK.
    - 0xAA, 0xFA, 0xEE, 0xFC, 0x00, 0xFF are dropped; stay in IDLE.
    - Any other byte pushes {0,0,b}.
  - EXT:
    - 0xF0 -> EXT_BRK.
    - 0xE0 stays in EXT and restarts the timer.
    - Any other byte pushes {0,1,b} -> IDLE.
  - BRK:
    - 0xE0 -> EXT.
    - 0xF0 stays in BRK and restarts the timer.
    - Any other byte pushes {1,0,b} -> IDLE.
  - EXT_BRK:
    - 0xE0 -> EXT.
    - 0xF0 -> BRK.
    - Any other byte pushes {1,1,b} -> IDLE.
- Housekeeping codes are filtered only in IDLE. After a prefix, every non-prefix byte is a scancode.
- Timeout: a 32-bit counter clears on every state entry and on every `new_byte`, and increments each cycle in EXT, BRK and EXT_BRK. When it equals TIMEOUT-1 with no `new_byte` in that cycle, the FSM goes to IDLE and nothing is pushed. If `new_byte` arrives in the timeout cycle, the byte wins.
- FIFO:
  - First-word-fall-through circular buffer. Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
  - `evt_rd` while empty is ignored.
  - Push and pop in the same cycle: both take effect and the count is unchanged. This holds when full: the pop frees the slot and the push is accepted with no overflow. When empty, the pop is ignored and the push is accepted.
  - Push while full with no pop: the event is dropped and `overflow` is set.
  - `overflow` stays set until an `ovf_clr` cycle. If `ovf_clr` and a new drop occur in the same cycle, the set wins.
- Reset values: FSM = IDLE, pointers = 0, `evt_count` = 0, `evt_empty` = 1, `evt_full` = 0, `overflow` = 0, `bv_q` = 0, timer = 0, `evt_data` = 0 (storage is cleared).
- Asserting `rst` mid-sequence discards any partial prefix and all queued events immediately.

## Timing
- `new_byte` combinational in cycle N. FSM and FIFO write registered at the end of N.
- `evt_empty`, `evt_count` and `evt_data` reflect the push from cycle N+1. Byte-to-event latency is 1 cycle after the edge.
- A pop strobed in cycle M updates `evt_data` and `evt_count` from cycle M+1.
- `evt_full`, `evt_empty` and `evt_count` are registered, or decoded from registered pointers only. No combinational path from `evt_rd` to `evt_data`.
- The block accepts a byte edge every cycle (no back-pressure to the receiver).

## Test plan
- Reset, then byte 0x1C -> after 1 cycle `evt_empty`=0, `evt_data`=0x01C, `evt_count`=1. Then `evt_rd` -> `evt_empty`=1.
- Sequence 0xF0, 0x1C, then 0xE0, 0x75, then 0xE0, 0xF0, 0x75 -> events 0x21C, 0x175, 0x375 in order. 0xAA and 0xFA sent in IDLE queue nothing.
- TIMEOUT=16: 0xF0 followed by a 20-cycle gap, then 0x1C -> event 0x01C (break discarded). Repeat with 0x1C arriving exactly at cycle 15 after 0xF0 -> 0x21C.
- DEPTH=4: push 5 make codes 0x10..0x14 -> `evt_full`=1, `overflow`=1, contents 0x010..0x013. `ovf_clr` -> `overflow`=0.
- Full FIFO, then `evt_rd` coincident with a new byte 0x22 -> `evt_count` stays 4, `overflow` stays 0, 0x022 is read last.
- `byte_valid` held high for 10 cycles -> exactly one event. `rst` asserted after 0xE0 -> all outputs at reset values; next byte 0x75 -> 0x075.
